wb_ram_responder: RTL and testbench

- Pipelined Wishbone B4 responder (slave) backed by an internal word RAM.
- The CPU's fetch unit and load/store path talk to it as initiator: cyc/stb/we/addr/data in; ack/stall/data out.
- Serves the boot/program region at 0xb0000000 with fixed, configurable read/write latency.
- Supports multiple outstanding requests with in-order acks, and a stall when its outstanding limit is reached.

---
 rtl/wb_ram_responder.sv | 104 ++++++++++
 tb/tb_wb_ram_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_responder.sv
// Pipelined Wishbone B4 responder backed by an internal word RAM with fixed latency.
// Define WB_RAM_RESP_ERR_EN to complete out-of-window accesses with o_wb_err.
module wb_ram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hb0000000,
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 2,
    parameter int          MAX_OUT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err
);

    localparam int            DEPTH   = 1 << ADDR_BITS;
    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    logic [31:0]          mem [DEPTH];
    logic [31:0]          offset;
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          rd_word;
    logic                 accept;
    logic                 addr_err;
    logic                 done;
    logic                 unused_offset_bits;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;

    logic                 pipe_valid [LATENCY];
    logic                 pipe_err   [LATENCY];
    logic [31:0]          pipe_data  [LATENCY];

    assign offset   = i_wb_addr - BASE_ADDR;
    assign word_idx = offset[ADDR_BITS+1:2];
    assign rd_word  = mem[word_idx];

`ifdef WB_RAM_RESP_ERR_EN
    assign addr_err           = |offset[31:ADDR_BITS+2];
    assign unused_offset_bits = ^offset[1:0];
`else
    assign addr_err           = 1'b0;
    assign unused_offset_bits = ^{offset[1:0], offset[31:ADDR_BITS+2]};
`endif

    // Requests presented while reset is held are never accepted, so they cannot touch the RAM.
    assign accept = reset & i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign done   = pipe_valid[LATENCY-1];

    always_comb begin
        count_next = count;
        if (accept && !done)
            count_next = count + 1'b1;
        else if (!accept && done)
            count_next = count - 1'b1;
    end

    // Dropping cyc abandons everything in flight, exactly like reset does.
    always_ff @(posedge clk) begin
        if (!reset || !i_wb_cyc) begin
            count      <= '0;
            o_wb_stall <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            count         <= count_next;
            o_wb_stall    <= (count_next == MAX_CNT);
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept & addr_err;
            pipe_data[0]  <= (accept && !i_wb_we && !addr_err) ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && i_wb_we && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b])
                    mem[word_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
            end
        end
    end

    // Completions are masked while cyc is low so an aborted request never reports back.
    assign o_wb_ack  = i_wb_cyc & pipe_valid[LATENCY-1] & ~pipe_err[LATENCY-1];
    assign o_wb_err  = i_wb_cyc & pipe_valid[LATENCY-1] &  pipe_err[LATENCY-1];
    assign o_wb_data = i_wb_cyc ? pipe_data[LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Self-checking bench for wb_ram_responder: scoreboard of expected completions.
// Honours WB_RAM_RESP_ERR_EN the same way the design does.
module tb_wb_ram_responder;

    localparam logic [31:0] BASE    = 32'hb0000000;
    localparam int          LATENCY = 2;

    logic        clk;
    logic        reset;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic        o_wb_err;

    typedef struct {
        bit          is_err;
        bit          check_data;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cycle     = 0;
    int   last_done = 0;
    bit   mon_en    = 0;

    wb_ram_responder #(
        .BASE_ADDR(BASE),
        .ADDR_BITS(10),
        .LATENCY  (LATENCY),
        .MAX_OUT  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_stb  (i_wb_stb),
        .i_wb_we   (i_wb_we),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data),
        .i_wb_sel  (i_wb_sel),
        .o_wb_data (o_wb_data),
        .o_wb_ack  (o_wb_ack),
        .o_wb_stall(o_wb_stall),
        .o_wb_err  (o_wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Completions are compared mid-cycle against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_wb_ack || o_wb_err) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_ack", {30'd0, o_wb_err, o_wb_ack}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("ack_kind", {30'd0, o_wb_err, o_wb_ack}, e.is_err ? 32'd2 : 32'd1);
                    checkOutput("ack_cycle", cycle, e.due);
                    if (e.check_data)
                        checkOutput("rdata", o_wb_data, e.data);
                    last_done = cycle;
                end
            end else begin
                checkOutput("idle_data", o_wb_data, 32'd0);
                if (sb.size() != 0 && sb[0].due < cycle) begin
                    checkOutput("missing_ack", cycle, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Presents one request and holds it until the responder stops stalling.
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_rdata,
                                 output int waited);
        exp_t e;
        @(posedge clk);
        #1;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        i_wb_sel  = sel;
        waited    = 0;
        while (o_wb_stall && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (o_wb_stall) begin
            checkOutput("stall_timeout", {31'd0, o_wb_stall}, 32'd0);
        end else begin
            e.is_err     = exp_err;
            e.check_data = exp_err || !we;
            e.data       = (exp_err || we) ? 32'd0 : exp_rdata;
            e.due        = cycle + LATENCY;
            sb.push_back(e);
        end
    endtask

    task automatic idleBus(input int n);
        @(posedge clk);
        #1;
        i_wb_stb = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++)
            @(posedge clk);
        #1;
        checkOutput("drain", sb.size(), 32'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int wsum;
        int t0;

        reset     = 1'b0;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = BASE;
        i_wb_data = 32'h0;
        i_wb_sel  = 4'hf;

        // Reset with a request held on the bus: nothing may be accepted or reported.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_ack", {31'd0, o_wb_ack}, 32'd0);
            checkOutput("rst_stall", {31'd0, o_wb_stall}, 32'd0);
            checkOutput("rst_data", o_wb_data, 32'd0);
        end
        i_wb_stb = 1'b0;
        reset    = 1'b1;
        mon_en   = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] write/read");
        applyStimulus(1, BASE + 32'h10, 32'hdeadbeef, 4'hf, 0, 32'h0, w);
        applyStimulus(0, BASE + 32'h10, 32'h0, 4'hf, 0, 32'hdeadbeef, w);
        idleBus(1);

        $display("[TB] byte enables");
        applyStimulus(1, BASE, 32'h11223344, 4'hf, 0, 32'h0, w);
        applyStimulus(1, BASE, 32'haabbccdd, 4'b0101, 0, 32'h0, w);
        applyStimulus(0, BASE, 32'h0, 4'hf, 0, 32'h11bb33dd, w);
        applyStimulus(1, BASE + 32'h10, 32'h00000000, 4'b0000, 0, 32'h0, w);
        applyStimulus(0, BASE + 32'h10, 32'h0, 4'hf, 0, 32'hdeadbeef, w);
        idleBus(1);

        $display("[TB] back-to-back with stall");
        applyStimulus(1, BASE + 32'h4, 32'h01010101, 4'hf, 0, 32'h0, w);
        applyStimulus(1, BASE + 32'h8, 32'h02020202, 4'hf, 0, 32'h0, w);
        applyStimulus(1, BASE + 32'hc, 32'h03030303, 4'hf, 0, 32'h0, w);
        idleBus(1);
        wsum = 0;
        applyStimulus(0, BASE, 32'h0, 4'hf, 0, 32'h11bb33dd, w);
        t0 = cycle + 1;
        wsum += w;
        applyStimulus(0, BASE + 32'h4, 32'h0, 4'hf, 0, 32'h01010101, w);
        wsum += w;
        applyStimulus(0, BASE + 32'h8, 32'h0, 4'hf, 0, 32'h02020202, w);
        wsum += w;
        applyStimulus(0, BASE + 32'hc, 32'h0, 4'hf, 0, 32'h03030303, w);
        wsum += w;
        idleBus(1);
        checkOutput("b2b_stall_waits", wsum, 32'd1);
        checkOutput("b2b_span_ok", {31'd0, (last_done - t0) <= 8}, 32'd1);

        $display("[TB] abort");
        applyStimulus(0, BASE + 32'h10, 32'h0, 4'hf, 0, 32'hdeadbeef, w);
        applyStimulus(0, BASE + 32'h4, 32'h0, 4'hf, 0, 32'h01010101, w);
        @(posedge clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        checkOutput("abort_stall", {31'd0, o_wb_stall}, 32'd0);
        repeat (4) @(posedge clk);
        applyStimulus(0, BASE + 32'h8, 32'h0, 4'hf, 0, 32'h02020202, w);
        applyStimulus(0, BASE + 32'hc, 32'h0, 4'hf, 0, 32'h03030303, w);
        idleBus(1);

        $display("[TB] reset mid-transfer");
        applyStimulus(1, BASE + 32'h20, 32'hcafef00d, 4'hf, 0, 32'h0, w);
        idleBus(0);
        applyStimulus(0, BASE + 32'h20, 32'h0, 4'hf, 0, 32'hcafef00d, w);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        i_wb_we   = 1'b1;
        i_wb_data = 32'h00000bad;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_ack", {31'd0, o_wb_ack}, 32'd0);
            checkOutput("midrst_stall", {31'd0, o_wb_stall}, 32'd0);
        end
        reset    = 1'b1;
        i_wb_stb = 1'b0;
        applyStimulus(0, BASE + 32'h20, 32'h0, 4'hf, 0, 32'hcafef00d, w);
        idleBus(1);

        $display("[TB] out-of-window access");
`ifdef WB_RAM_RESP_ERR_EN
        applyStimulus(1, BASE + 32'h1000, 32'h12345678, 4'hf, 1, 32'h0, w);
        applyStimulus(0, BASE, 32'h0, 4'hf, 0, 32'h11bb33dd, w);
        applyStimulus(0, BASE - 32'h4, 32'h0, 4'hf, 1, 32'h0, w);
`else
        applyStimulus(1, BASE + 32'h1000, 32'h12345678, 4'hf, 0, 32'h0, w);
        applyStimulus(0, BASE, 32'h0, 4'hf, 0, 32'h12345678, w);
`endif
        idleBus(2);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
